// File: rtl/fp_add_subt_unit_pkg.sv
// ============================================================================
// Package : fp_add_subt_unit_pkg
// Purpose : Shared constants and FSM encoding for the binary32 add/sub unit.
// Contents: default operand geometry (W/EW/SW), exponent bias, all-ones
//           exponent, canonical quiet NaN, and the 3-bit state encoding.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fp_add_subt_unit_pkg;

  localparam int FP_W  = 32;
  localparam int FP_EW = 8;
  localparam int FP_SW = 23;

  localparam int BIAS    = 2**(FP_EW-1) - 1;
  localparam int EXP_MAX = 2*BIAS + 1;     // all-ones exponent (inf/NaN)

  localparam logic [FP_W-1:0] QNAN_CANON = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWAP  = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_ROUND = 3'd5,
    S_READY = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ============================================================================
// Module  : fp_lzc
// Purpose : Combinational leading-zero counter over the extended significand.
// Ports   : i_data  [WIDTH-1:0]  value to scan (MSB first)
//           o_count [CW-1:0]     number of leading zeros (WIDTH when zero)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // Scan upward; the highest set bit is the last one to write the count.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_subt_unit.sv
// ============================================================================
// Module  : fp_add_subt_unit
// Purpose : Multi-cycle IEEE-754 binary32 adder/subtractor, responder side of
//           the beg/ready/ack handshake. Fixed 5-edge latency from accept to
//           ready; result and flags held until acknowledged.
// Ports   : clk, reset (async, active-high)
//           beg_add_subt   start request (sampled in S_IDLE)
//           ack_add_subt   result taken   (sampled in S_READY)
//           add_subt       0 = A+B, 1 = A-B
//           data_a/data_b  operands
//           ready_add_subt result valid
//           result         sum/difference
//           overflow_flag  saturated to +/-inf
//           underflow_flag nonzero result flushed to signed zero
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_add_subt_unit
  import fp_add_subt_unit_pkg::*;
#(
  parameter int W  = FP_W,
  parameter int EW = FP_EW,
  parameter int SW = FP_SW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         add_subt,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         ready_add_subt,
  output logic [W-1:0] result,
  output logic         overflow_flag,
  output logic         underflow_flag
);

  localparam int ESW = SW + 4;             // hidden + fraction + G/R/S
  localparam int LZW = $clog2(ESW);
  localparam int SHW = $clog2(ESW + 1);
  localparam int XW  = EW + 2;             // signed working exponent
  localparam logic [EW-1:0]        EXP_ONES = EW'(EXP_MAX);
  localparam logic signed [XW-1:0] EXP_TOP  = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);

  state_t r_state, w_next;

  logic [W-1:0]   r_a, r_b;
  logic           r_op;
  logic           r_big_sign, r_sub;
  logic [EW-1:0]  r_big_exp, r_sml_exp;
  logic [ESW-1:0] r_big_sig, r_sml_sig;
  logic           r_nan, r_inf, r_inf_sign;
  logic [ESW:0]   r_sum;
  logic [ESW-1:0] r_norm_sig;
  logic signed [XW-1:0] r_norm_exp;
  logic           r_zero;
  logic [W-1:0]   r_result;
  logic           r_ovf, r_unf;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (beg_add_subt) w_next = S_SWAP;
      S_SWAP:  w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_READY;
      S_READY: if (ack_add_subt) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- swap / special detection ----------------
  logic          w_sign_a, w_sign_b, w_a_big;
  logic [EW-1:0] w_exp_a, w_exp_b;
  logic [W-2:0]  w_mag_a, w_mag_b, w_mag_big, w_mag_sml;
  logic          w_nan_a, w_nan_b, w_inf_a, w_inf_b;

  assign w_sign_a  = r_a[W-1];
  assign w_sign_b  = r_b[W-1] ^ r_op;
  assign w_exp_a   = r_a[W-2:SW];
  assign w_exp_b   = r_b[W-2:SW];
  // Zero exponent means zero or denormal; both become an exact zero.
  assign w_mag_a   = (w_exp_a == '0) ? '0 : r_a[W-2:0];
  assign w_mag_b   = (w_exp_b == '0) ? '0 : r_b[W-2:0];
  assign w_a_big   = (w_mag_a >= w_mag_b);
  assign w_mag_big = w_a_big ? w_mag_a : w_mag_b;
  assign w_mag_sml = w_a_big ? w_mag_b : w_mag_a;
  assign w_nan_a   = (w_exp_a == EXP_ONES) && (r_a[SW-1:0] != '0);
  assign w_nan_b   = (w_exp_b == EXP_ONES) && (r_b[SW-1:0] != '0);
  assign w_inf_a   = (w_exp_a == EXP_ONES) && (r_a[SW-1:0] == '0);
  assign w_inf_b   = (w_exp_b == EXP_ONES) && (r_b[SW-1:0] == '0);

  // ---------------- alignment ----------------
  logic [EW-1:0]  w_diff;
  logic [SHW-1:0] w_shamt;
  logic [ESW-1:0] w_shifted, w_lost;

  assign w_diff    = r_big_exp - r_sml_exp;
  assign w_shamt   = (w_diff > EW'(ESW)) ? SHW'(ESW) : SHW'(w_diff);
  assign w_shifted = r_sml_sig >> w_shamt;
  assign w_lost    = r_sml_sig & ~({ESW{1'b1}} << w_shamt);

  // ---------------- normalisation ----------------
  logic [LZW-1:0]       w_lzc;
  logic signed [XW-1:0] w_big_exp_x, w_lzc_x;

  fp_lzc #(.WIDTH(ESW), .CW(LZW)) u_lzc (
    .i_data  (r_sum[ESW-1:0]),
    .o_count (w_lzc)
  );

  assign w_big_exp_x = {2'b00, r_big_exp};
  assign w_lzc_x     = {{(XW-LZW){1'b0}}, w_lzc};

  // ---------------- rounding (RNE on G/R/S) ----------------
  logic [SW:0]          w_mant;
  logic                 w_rup;
  logic [SW+1:0]        w_mant_r;
  logic signed [XW-1:0] w_exp_r;
  logic [SW-1:0]        w_frac_r;

  assign w_mant   = r_norm_sig[ESW-1:3];
  assign w_rup    = r_norm_sig[2] & (r_norm_sig[1] | r_norm_sig[0] | w_mant[0]);
  assign w_mant_r = {1'b0, w_mant} + (SW+2)'(w_rup);
  // Rollover to 10.000... bumps the exponent; the fraction is then all zero.
  assign w_exp_r  = r_norm_exp + (w_mant_r[SW+1] ? EXP_ONE : '0);
  assign w_frac_r = w_mant_r[SW+1] ? w_mant_r[SW:1] : w_mant_r[SW-1:0];

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_big_sign <= 1'b0;
      r_sub      <= 1'b0;
      r_big_exp  <= '0;
      r_sml_exp  <= '0;
      r_big_sig  <= '0;
      r_sml_sig  <= '0;
      r_nan      <= 1'b0;
      r_inf      <= 1'b0;
      r_inf_sign <= 1'b0;
      r_sum      <= '0;
      r_norm_sig <= '0;
      r_norm_exp <= '0;
      r_zero     <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (beg_add_subt) begin
          r_a      <= data_a;
          r_b      <= data_b;
          r_op     <= add_subt;
          r_result <= '0;
          r_ovf    <= 1'b0;
          r_unf    <= 1'b0;
        end
        S_SWAP: begin
          r_big_sign <= w_a_big ? w_sign_a : w_sign_b;
          r_sub      <= w_sign_a ^ w_sign_b;
          r_big_exp  <= w_mag_big[W-2:SW];
          r_sml_exp  <= w_mag_sml[W-2:SW];
          r_big_sig  <= {(w_mag_big[W-2:SW] != '0), w_mag_big[SW-1:0], 3'b000};
          r_sml_sig  <= {(w_mag_sml[W-2:SW] != '0), w_mag_sml[SW-1:0], 3'b000};
          r_nan      <= w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sign_a ^ w_sign_b));
          r_inf      <= w_inf_a | w_inf_b;
          r_inf_sign <= w_inf_a ? w_sign_a : w_sign_b;
        end
        S_ALIGN: r_sml_sig <= w_shifted | {{(ESW-1){1'b0}}, |w_lost};
        S_ADD:   r_sum <= r_sub ? ({1'b0, r_big_sig} - {1'b0, r_sml_sig})
                                : ({1'b0, r_big_sig} + {1'b0, r_sml_sig});
        S_NORM: begin
          r_zero <= (r_sum == '0);
          if (r_sum[ESW]) begin
            // Carry out: shift right one, keeping the dropped bit as sticky.
            r_norm_sig <= {r_sum[ESW:2], r_sum[1] | r_sum[0]};
            r_norm_exp <= w_big_exp_x + EXP_ONE;
          end else begin
            r_norm_sig <= r_sum[ESW-1:0] << w_lzc;
            r_norm_exp <= w_big_exp_x - w_lzc_x;
          end
        end
        S_ROUND: begin
          if (r_nan) begin
            r_result <= QNAN_CANON;
          end else if (r_inf) begin
            r_result <= {r_inf_sign, EXP_ONES, {SW{1'b0}}};
          end else if (r_zero) begin
            r_result <= '0;
          end else if (w_exp_r >= EXP_TOP) begin
            r_result <= {r_big_sign, EXP_ONES, {SW{1'b0}}};
            r_ovf    <= 1'b1;
          end else if (w_exp_r[XW-1] || (w_exp_r == '0)) begin
            r_result <= {r_big_sign, {(W-1){1'b0}}};
            r_unf    <= 1'b1;
          end else begin
            r_result <= {r_big_sign, w_exp_r[EW-1:0], w_frac_r};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_add_subt = (r_state == S_READY);
  assign result         = r_result;
  assign overflow_flag  = r_ovf;
  assign underflow_flag = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_subt_unit.sv
// ============================================================================
// Module  : tb_fp_add_subt_unit
// Purpose : Self-checking bench for fp_add_subt_unit: directed vector table,
//           randomized operands against an exact-arithmetic reference model,
//           and handshake / mid-operation reset sequences.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_add_subt_unit;

  logic        clk = 1'b0;
  logic        reset, beg, ack, op;
  logic [31:0] da, db;
  logic        ready;
  logic [31:0] res;
  logic        ovf, unf;

  int n_vec = 0;
  int n_bad = 0;

  fp_add_subt_unit dut (
    .clk            (clk),
    .reset          (reset),
    .beg_add_subt   (beg),
    .ack_add_subt   (ack),
    .add_subt       (op),
    .data_a         (da),
    .data_b         (db),
    .ready_add_subt (ready),
    .result         (res),
    .overflow_flag  (ovf),
    .underflow_flag (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, are summed
  // exactly, then rounded to nearest-even into binary32.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic o,
                                    output logic [31:0] r, output logic fo, output logic fu);
    logic sa, sb, s;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [319:0] va, vb, mag, mant, rem, half;
    int p, e, sh;
    sa = a[31]; sb = b[31] ^ o;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    fo = 1'b0; fu = 1'b0; r = 32'h0;
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb)) begin
      r = 32'h7FC00000;
    end else if (ea == 8'hFF) begin
      r = {sa, 8'hFF, 23'h0};
    end else if (eb == 8'hFF) begin
      r = {sb, 8'hFF, 23'h0};
    end else begin
      va = (ea == 0) ? '0 : (320'({1'b1, fa}) << (ea - 8'd1));
      vb = (eb == 0) ? '0 : (320'({1'b1, fb}) << (eb - 8'd1));
      if (sa == sb)      begin mag = va + vb; s = sa; end
      else if (va >= vb) begin mag = va - vb; s = sa; end
      else               begin mag = vb - va; s = sb; end
      if (mag != 0) begin
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        e = p - 22;
        if (p > 23) begin
          sh   = p - 23;
          mant = mag >> sh;
          rem  = mag & ((320'd1 << sh) - 320'd1);
          half = 320'd1 << (sh - 1);
          if (rem > half || (rem == half && mant[0])) mant = mant + 320'd1;
        end else begin
          mant = mag << (23 - p);
        end
        if (mant[24]) begin mant = mant >> 1; e++; end
        if (e >= 255)   begin r = {s, 8'hFF, 23'h0}; fo = 1'b1; end
        else if (e <= 0) begin r = {s, 31'h0}; fu = 1'b1; end
        else             r = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        output logic [31:0] r, output logic fo, output logic fu, output int lat);
    @(negedge clk);
    da = a; db = b; op = o; beg = 1'b1;
    @(posedge clk); #1;
    beg = 1'b0;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res; fo = ovf; fu = unf;
  endtask

  task automatic do_ack;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  initial begin
    logic [31:0] r, er;
    logic fo, fu, efo, efu, seen;
    int lat;

    tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
    tbl[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tbl[2]  = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0};
    tbl[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    tbl[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0};
    tbl[5]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0};
    tbl[6]  = '{32'h4B800000, 32'h40400000, 1'b0, 32'h4B800002, 1'b0, 1'b0};
    tbl[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0};
    tbl[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0};
    tbl[9]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tbl[10] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1};
    tbl[11] = '{32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 1'b0, 1'b1};
    tbl[12] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0};
    tbl[13] = '{32'h40000000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0};

    reset = 1'b1; beg = 1'b0; ack = 1'b0; op = 1'b0; da = '0; db = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", res, 32'h0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_unf", 32'(unf), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, r, fo, fu, lat);
      check($sformatf("tbl%0d_result", i), r, tbl[i].r);
      check($sformatf("tbl%0d_ovf", i), 32'(fo), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_unf", i), 32'(fu), 32'(tbl[i].unf));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd5);
      do_ack();
      check($sformatf("tbl%0d_ready_drop", i), 32'(ready), 32'd0);
    end

    // Randomized operands against the reference model
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a, b, t;
      logic o;
      int m, e2;
      a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      m = int'($urandom_range(0, 9));
      if (m < 5) begin
        e2 = int'(a[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e2 < 1) e2 = 1;
        if (e2 > 254) e2 = 254;
        b = {1'($urandom), 8'(e2), 23'($urandom)};
      end else if (m < 7) begin
        b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      end else if (m == 7) begin
        a[30:23] = 8'($urandom_range(250, 254));
        b = {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
      end else if (m == 8) begin
        b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 7))};
      end else begin
        case ($urandom_range(0, 3))
          0:       b = 32'h00000000;
          1:       b = 32'h7F800000;
          2:       b = 32'h7FC00001;
          default: b = 32'h00000123;
        endcase
        b[31] = 1'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
      o = 1'($urandom);
      ref_model(a, b, o, er, efo, efu);
      run_op(a, b, o, r, fo, fu, lat);
      check($sformatf("rnd%0d_result %h%s%h", k, a, o ? "-" : "+", b), r, er);
      check($sformatf("rnd%0d_ovf", k), 32'(fo), 32'(efo));
      check($sformatf("rnd%0d_unf", k), 32'(fu), 32'(efu));
      check($sformatf("rnd%0d_latency", k), 32'(lat), 32'd5);
      do_ack();
    end

    // Handshake: beg while busy / ready ignored, ack held off, ack+beg together
    @(negedge clk);
    da = 32'h3F800000; db = 32'h40000000; op = 1'b0; beg = 1'b1;
    @(posedge clk); #1;
    da = 32'h7F7FFFFF; db = 32'h7F7FFFFF;   // still high in S_SWAP: ignored
    @(posedge clk); #1;
    beg = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hs_latency", 32'(lat), 32'd5);
    check("hs_result", res, 32'h40400000);
    for (int c = 0; c < 10; c++) begin
      beg = (c == 4);
      @(posedge clk); #1;
      check($sformatf("hs_hold%0d", c), {ready, res[30:0]}, {1'b1, 31'h40400000});
    end
    beg = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    beg = 1'b0; ack = 1'b0;
    check("hs_ack_beg_ready", 32'(ready), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    check("hs_no_second_result", 32'(seen), 32'd0);

    // Reset while in S_ALIGN
    @(negedge clk);
    da = 32'h7F7FFFFF; db = 32'h7F7FFFFF; op = 1'b0; beg = 1'b1;
    @(posedge clk); #1;
    beg = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_result", res, 32'h0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    check("rst_mid_unf", 32'(unf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    check("rst_mid_no_ready", 32'(seen), 32'd0);
    run_op(32'h40000000, 32'h40000000, 1'b0, r, fo, fu, lat);
    check("post_rst_result", r, 32'h40800000);
    check("post_rst_latency", 32'(lat), 32'd5);
    check("post_rst_flags", {30'd0, fo, fu}, 32'd0);
    do_ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
